// File: rtl/cpu_pkg.sv
// Shared register-file parameters, write-enable encodings
// and the half-word merge helper.
package cpu_pkg;

  localparam int NUM_REGS = 8;
  localparam int ENC_W    = 3;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 2;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_FULL = 2'b11;

  function automatic logic [DATA_W-1:0] merge_half(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [1:0]        we
  );
    logic [DATA_W-1:0] res;
    unique case (we)
      WE_LO:   res = {old_w[31:16], new_w[15:0]};
      WE_HI:   res = {new_w[31:16], old_w[15:0]};
      WE_FULL: res = new_w;
      default: res = old_w;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters, sticky error flag
// and the decode stall logic.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       we,
  input  logic [ENC_W-1:0] wenc,
  input  logic             issue_valid,
  input  logic [ENC_W-1:0] issue_dest_enc,
  input  logic [ENC_W-1:0] rd_enc1,
  input  logic [ENC_W-1:0] rd_enc2,
  output logic             hazard_stall,
  output logic             sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] pending;
  logic                err_set;
  logic                full_ret;

  assign full_ret = (we == WE_FULL);

  always_comb begin
    inc     = '0;
    dec     = '0;
    pending = '0;
    err_set = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = issue_valid && (issue_dest_enc == ENC_W'(r));
      dec[r] = (we != WE_NONE) && (wenc == ENC_W'(r));
      pending[r] = (cnt[r] > CNT_ONE) ||
                   ((cnt[r] == CNT_ONE) &&
                    !(full_ret && (wenc == ENC_W'(r))));
      // overflowed issue or orphan retire; the same-cycle pair cancels
      if (inc[r] && !dec[r] && (cnt[r] == CNT_MAX))
        err_set = 1'b1;
      if (dec[r] && !inc[r] && (cnt[r] == '0))
        err_set = 1'b1;
    end
  end

  assign hazard_stall = pending[rd_enc1] | pending[rd_enc2] |
    (issue_valid && (cnt[issue_dest_enc] == CNT_MAX));

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r] && (cnt[r] != CNT_MAX))
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec[r] && !inc[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      if (err_set)
        sb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 8x32 register file: writeback port, two bypassed read
// ports, registered debug read and write scoreboard.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        reg_file_write_enable,
  input  logic [ENC_W-1:0]  reg_file_register_encoding,
  input  logic [DATA_W-1:0] reg_file_writeback_data,
  input  logic [ENC_W-1:0]  rd_enc1,
  input  logic [ENC_W-1:0]  rd_enc2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              issue_valid,
  input  logic [ENC_W-1:0]  issue_dest_enc,
  output logic              hazard_stall,
  input  logic [ENC_W-1:0]  dbg_enc,
  output logic [DATA_W-1:0] dbg_data,
  output logic              sb_error
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        we;
  logic [ENC_W-1:0]  wenc;
  logic [DATA_W-1:0] wdata;

  assign we    = reg_file_write_enable;
  assign wenc  = reg_file_register_encoding;
  assign wdata = reg_file_writeback_data;

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_enc];
      if (we != WE_NONE)
        regs[wenc] <= merge_half(regs[wenc], wdata, we);
    end
  end

  // merge_half passes the stored word through when we is WE_NONE
  assign rd_data1 = (wenc == rd_enc1) ?
    merge_half(regs[rd_enc1], wdata, we) : regs[rd_enc1];
  assign rd_data2 = (wenc == rd_enc2) ?
    merge_half(regs[rd_enc2], wdata, we) : regs[rd_enc2];

  reg_scoreboard u_sb (
    .clk            (clk),
    .resetn         (resetn),
    .we             (we),
    .wenc           (wenc),
    .issue_valid    (issue_valid),
    .issue_dest_enc (issue_dest_enc),
    .rd_enc1        (rd_enc1),
    .rd_enc2        (rd_enc2),
    .hazard_stall   (hazard_stall),
    .sb_error       (sb_error)
  );

endmodule
